// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter driven by an internal prescaler tick.
// The prescaler acts as a clock enable, so all state lives on clk.
// The count runs down to zero, then the block parks in EXPIRED until load or reset.
module countdown_timer #(
  parameter int WIDTH = 5,
  parameter int DIV_W = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] out,
  output logic             running,
  output logic             done,
  output logic             expired
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] prescaler;

  // A tick is due when the prescaler is about to wrap. The RUN branch
  // below also gates it with pause, because pausing suppresses the tick.
  logic tick_due;
  assign tick_due = (prescaler == {DIV_W{1'b1}});

  // Single FSM: state, count, prescaler and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out       <= '0;
      prescaler <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
      expired   <= 1'b0;
    end else begin
      // done is a one-cycle pulse; only the expiring tick raises it
      done <= 1'b0;
      if (load) begin
        out       <= load_val;
        prescaler <= '0;
        state     <= IDLE;
        running   <= 1'b0;
        expired   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // pause outranks start; a zero count can never start
            if (!pause && start && (out != '0)) begin
              state     <= RUN;
              prescaler <= '0;
              running   <= 1'b1;
            end
          end
          RUN: begin
            if (pause) begin
              // freeze: prescaler keeps its value and any due tick is dropped
              state   <= PAUSED;
              running <= 1'b0;
            end else begin
              prescaler <= prescaler + 1'b1;
              if (tick_due) begin
                out <= out - WIDTH'(1);
                if (out == WIDTH'(1)) begin
                  state   <= EXPIRED;
                  running <= 1'b0;
                  expired <= 1'b1;
                  done    <= 1'b1;
                end
              end
            end
          end
          PAUSED: begin
            // resume from the held prescaler value; pause wins over start
            if (!pause && start) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          EXPIRED: begin
            // only load or reset leaves this state
            expired <= 1'b1;
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
            expired <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed tests with hand-computed expectations, DIV_W=2.
module tb_countdown_timer;

  localparam int WIDTH = 5;
  localparam int DIV_W = 2;

  logic             clk;
  logic             rst_n;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] out;
  logic             running;
  logic             done;
  logic             expired;

  int checks;
  int errors;

  countdown_timer #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .out      (out),
    .running  (running),
    .done     (done),
    .expired  (expired)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge and settle 1 ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // load a value and return to IDLE (one edge)
  task automatic do_load(input logic [WIDTH-1:0] v);
    load_val = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  // start sampled at the next edge E; returns 1 ns after E
  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0;
    step();
    step();
    checks++;
    if (out !== 5'd0 || running !== 1'b0 || done !== 1'b0 || expired !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out=%0d running=%b done=%b expired=%b, required 0 0 0 0",
               out, running, done, expired);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (out !== 5'd0 || running !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: out=%0d running=%b, required 0 0", out, running);
    end
    $display("test_reset done");
  endtask

  // load 3, start at E: out 2 at E+4, 1 at E+8, 0 at E+12 with done pulse
  task automatic test_basic();
    logic [WIDTH-1:0] exp_out;
    do_load(5'd3);
    checks++;
    if (out !== 5'd3 || running !== 1'b0) begin
      errors++;
      $display("FAIL basic_load: out=%0d running=%b, required 3 0", out, running);
    end
    do_start();
    checks++;
    if (out !== 5'd3 || running !== 1'b1) begin
      errors++;
      $display("FAIL basic_start: out=%0d running=%b, required 3 1", out, running);
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_out = 5'd3 - 5'(k / 4);
      checks++;
      if (out !== exp_out || done !== (k == 12)) begin
        errors++;
        $display("FAIL basic_count E+%0d: out=%0d done=%b, required %0d %b",
                 k, out, done, exp_out, (k == 12));
      end
    end
    checks++;
    if (expired !== 1'b1 || running !== 1'b0) begin
      errors++;
      $display("FAIL basic_expire: expired=%b running=%b, required 1 0", expired, running);
    end
    step();
    checks++;
    if (done !== 1'b0 || out !== 5'd0 || expired !== 1'b1) begin
      errors++;
      $display("FAIL basic_done_pulse: done=%b out=%0d expired=%b, required 0 0 1",
               done, out, expired);
    end
    $display("test_basic done");
  endtask

  // pause after two increments (prescaler=2), held 10 cycles, resume
  task automatic test_pause();
    do_load(5'd5);
    do_start();
    step();
    step();
    pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (out !== 5'd5 || running !== 1'b0) begin
        errors++;
        $display("FAIL pause_hold cycle %0d: out=%0d running=%b, required 5 0", k, out, running);
      end
    end
    pause = 1'b0;
    do_start();
    checks++;
    if (out !== 5'd5 || running !== 1'b1) begin
      errors++;
      $display("FAIL pause_resume: out=%0d running=%b, required 5 1", out, running);
    end
    step();
    checks++;
    if (out !== 5'd5) begin
      errors++;
      $display("FAIL pause_residual1: out=%0d, required 5", out);
    end
    step();
    checks++;
    if (out !== 5'd4) begin
      errors++;
      $display("FAIL pause_residual2: out=%0d, required 4", out);
    end
    $display("test_pause done");
  endtask

  // pause exactly on the tick cycle: tick dropped, fires on first RUN edge
  task automatic test_pause_tick();
    do_load(5'd5);
    do_start();
    step();
    step();
    step();
    pause = 1'b1;
    step();
    pause = 1'b0;
    checks++;
    if (out !== 5'd5 || running !== 1'b0) begin
      errors++;
      $display("FAIL pause_tick_suppressed: out=%0d running=%b, required 5 0", out, running);
    end
    do_start();
    checks++;
    if (out !== 5'd5 || running !== 1'b1) begin
      errors++;
      $display("FAIL pause_tick_resume: out=%0d running=%b, required 5 1", out, running);
    end
    step();
    checks++;
    if (out !== 5'd4) begin
      errors++;
      $display("FAIL pause_tick_first_edge: out=%0d, required 4", out);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (out !== ((k == 4) ? 5'd3 : 5'd4)) begin
        errors++;
        $display("FAIL pause_tick_period +%0d: out=%0d, required %0d", k, out,
                 (k == 4) ? 3 : 4);
      end
    end
    $display("test_pause_tick done");
  endtask

  // load while running, then load and start together
  task automatic test_load_override();
    do_load(5'd5);
    do_start();
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (out !== 5'd4 || running !== 1'b1) begin
      errors++;
      $display("FAIL load_setup: out=%0d running=%b, required 4 1", out, running);
    end
    do_load(5'd9);
    checks++;
    if (out !== 5'd9 || running !== 1'b0) begin
      errors++;
      $display("FAIL load_in_run: out=%0d running=%b, required 9 0", out, running);
    end
    load_val = 5'd6;
    load = 1'b1;
    start = 1'b1;
    step();
    load = 1'b0;
    start = 1'b0;
    step();
    checks++;
    if (out !== 5'd6 || running !== 1'b0) begin
      errors++;
      $display("FAIL load_beats_start: out=%0d running=%b, required 6 0", out, running);
    end
    do_start();
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL load_then_start: running=%b, required 1", running);
    end
    $display("test_load_override done");
  endtask

  // start with a zero count is ignored
  task automatic test_zero_start();
    do_load(5'd0);
    start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (out !== 5'd0 || running !== 1'b0 || done !== 1'b0 || expired !== 1'b0) begin
        errors++;
        $display("FAIL zero_start cycle %0d: out=%0d running=%b done=%b expired=%b, required 0 0 0 0",
                 k, out, running, done, expired);
      end
    end
    start = 1'b0;
    $display("test_zero_start done");
  endtask

  // start and pause have no effect once expired
  task automatic test_expired_hold();
    do_load(5'd1);
    do_start();
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (out !== 5'd0 || done !== 1'b1 || expired !== 1'b1) begin
      errors++;
      $display("FAIL expire_from_1: out=%0d done=%b expired=%b, required 0 1 1", out, done, expired);
    end
    start = 1'b1;
    pause = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (out !== 5'd0 || expired !== 1'b1 || running !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL expired_hold cycle %0d: out=%0d expired=%b running=%b done=%b, required 0 1 0 0",
                 k, out, expired, running, done);
      end
    end
    start = 1'b0;
    pause = 1'b0;
    $display("test_expired_hold done");
  endtask

  // reset between edges while running at 7 clears outputs immediately
  task automatic test_async_reset();
    do_load(5'd7);
    do_start();
    step();
    checks++;
    if (out !== 5'd7 || running !== 1'b1) begin
      errors++;
      $display("FAIL async_setup: out=%0d running=%b, required 7 1", out, running);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out !== 5'd0 || running !== 1'b0 || expired !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: out=%0d running=%b expired=%b done=%b, required 0 0 0 0",
               out, running, expired, done);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (out !== 5'd0 || running !== 1'b0) begin
      errors++;
      $display("FAIL async_release: out=%0d running=%b, required 0 0", out, running);
    end
    $display("test_async_reset done");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_pause();
    test_pause_tick();
    test_load_override();
    test_zero_start();
    test_expired_hold();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
